load_store_unit: RTL and testbench

//  Sits between the MEM pipeline stage and the byte-addressed, big-endian, word-wide data memory.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_if.sv | 32 +++
 rtl/lsu_lane_align.sv | 44 ++++
 rtl/load_store_unit.sv | 121 ++++++++++++
 tb/tb_load_store_unit.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions.
//   SIZE_*      : req_size encodings (2'b11 is illegal)
//   ST_*        : FSM state encodings
//   lsu_req_t   : request fields latched at accept
//   size_bytes  : access width in bytes for a size code
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_RD   = 3'd1;
    localparam state_t ST_CAP  = 3'd2;
    localparam state_t ST_WR   = 3'd3;
    localparam state_t ST_WREL = 3'd4;
    localparam state_t ST_RESP = 3'd5;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    // Illegal size reports 4 so the range check stays well defined; the
    // request is rejected by the size check anyway.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_bytes = 3'd1;
            SIZE_HALF: size_bytes = 3'd2;
            default:   size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Load/store unit bus bundle: MEM-stage request/response plus data-memory port.
//   slave  : the LSU side (takes requests, drives memory strobes)
//   master : the pipeline/memory side
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_data;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_data,
        output req_ready, resp_valid, resp_rdata, resp_error,
               mem_address, mem_write_data, mem_read, mem_write
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_data,
        input  req_ready, resp_valid, resp_rdata, resp_error,
               mem_address, mem_write_data, mem_read, mem_write
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Big-endian lane steering (combinational).
//   word       : memory word (byte offset 0 lives in bits [31:24])
//   offset     : byte address [1:0]
//   size, uns  : access size and zero-extend select
//   wdata      : right-justified store data
//   load_data  : extended load result
//   store_word : word with only the addressed lane replaced
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);
    logic [4:0]  sh;
    logic [31:0] lane;

    always_comb begin
        sh         = '0;
        lane       = '0;
        load_data  = word;
        store_word = wdata;
        case (size)
            SIZE_BYTE: begin
                // 3-offset == ~offset for a 2-bit offset
                sh         = {~offset, 3'b000};
                lane       = word >> sh;
                load_data  = {{24{lane[7] & ~uns}}, lane[7:0]};
                store_word = (word & ~(32'h0000_00FF << sh)) | ({24'h0, wdata[7:0]} << sh);
            end
            SIZE_HALF: begin
                sh         = offset[1] ? 5'd0 : 5'd16;
                lane       = word >> sh;
                load_data  = {{16{lane[15] & ~uns}}, lane[15:0]};
                store_word = (word & ~(32'h0000_FFFF << sh)) | ({16'h0, wdata[15:0]} << sh);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a big-endian word-wide data memory.
//   clk, rst_n : clock, async active-low reset
//   bus        : lsu_if.slave -- request/response handshake and memory strobes
// Sub-word stores are read-modify-write. Errors (illegal size, misalignment,
// out of range) go straight to RESP without touching memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 2048
) (
    input  logic  clk,
    input  logic  rst_n,
    lsu_if.slave  bus
);
    state_t      state_q, state_d;
    lsu_req_t    req_q, req_d;
    logic        err_q, err_d;
    logic [31:0] word_buf_q, word_buf_d;

    logic        accept;
    logic        req_err;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign accept = bus.req_valid && (state_q == ST_IDLE);

    always_comb begin
        req_err = (bus.req_size == 2'b11)
               || (bus.req_size == SIZE_HALF && bus.req_addr[0])
               || (bus.req_size == SIZE_WORD && bus.req_addr[1:0] != 2'b00)
               || (({1'b0, bus.req_addr} + 33'(size_bytes(bus.req_size))) > 33'(MEM_BYTES));
    end

    lsu_lane_align u_align (
        .word       (word_buf_q),
        .offset     (req_q.addr[1:0]),
        .size       (req_q.size),
        .uns        (req_q.uns),
        .wdata      (req_q.wdata),
        .load_data  (load_ext),
        .store_word (merged)
    );

    // State register and request/data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            err_q      <= 1'b0;
            word_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            err_q      <= err_d;
            word_buf_q <= word_buf_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.req_valid) begin
                if (req_err)                                          state_d = ST_RESP;
                else if (bus.req_write && bus.req_size == SIZE_WORD)  state_d = ST_WR;
                else                                                  state_d = ST_RD;
            end
            ST_RD:   state_d = ST_CAP;
            ST_CAP:  state_d = req_q.write ? ST_WR : ST_RESP;
            ST_WR:   state_d = ST_WREL;
            ST_WREL: state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath registers
    always_comb begin
        req_d      = req_q;
        err_d      = err_q;
        word_buf_d = word_buf_q;
        if (accept) begin
            req_d.write = bus.req_write;
            req_d.size  = bus.req_size;
            req_d.uns   = bus.req_unsigned;
            req_d.addr  = bus.req_addr;
            req_d.wdata = bus.req_wdata;
            err_d       = req_err;
        end
        if (state_q == ST_CAP) word_buf_d = bus.mem_data;
    end

    // Outputs are a pure decode of state, so a reset drops both strobes at once.
    always_comb begin
        bus.req_ready      = (state_q == ST_IDLE);
        bus.resp_valid     = 1'b0;
        bus.resp_error     = 1'b0;
        bus.resp_rdata     = '0;
        bus.mem_address    = '0;
        bus.mem_write_data = '0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        case (state_q)
            ST_RD, ST_CAP: begin
                bus.mem_address = {req_q.addr[31:2], 2'b00};
                bus.mem_read    = (state_q == ST_RD);
            end
            ST_WR, ST_WREL: begin
                bus.mem_address    = {req_q.addr[31:2], 2'b00};
                bus.mem_write_data = (req_q.size == SIZE_WORD) ? req_q.wdata : merged;
                bus.mem_write      = (state_q == ST_WR);
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_error = err_q;
                bus.resp_rdata = (!req_q.write && !err_q) ? load_ext : 32'h0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_if bus();

    load_store_unit #(.MEM_BYTES(2048)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Data memory: samples/commits on the rising edge of each strobe.
    logic [31:0] mem [0:511];
    always @(posedge bus.mem_read) begin
        #1;
        bus.mem_data = mem[bus.mem_address[10:2]];
    end
    always @(posedge bus.mem_write) begin
        #1;
        mem[bus.mem_address[10:2]] = bus.mem_write_data;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Strobe monitor
    int   rd_pulses = 0, wr_pulses = 0, resp_pulses = 0, strobe_viol = 0;
    logic prev_rd = 1'b0, prev_wr = 1'b0;
    always @(negedge clk) begin
        if (bus.mem_read && !prev_rd) rd_pulses++;
        if (bus.mem_write && !prev_wr) wr_pulses++;
        if (bus.resp_valid) resp_pulses++;
        if ((bus.mem_read && bus.mem_write) || (bus.mem_read && prev_rd) || (bus.mem_write && prev_wr))
            strobe_viol++;
        prev_rd = bus.mem_read;
        prev_wr = bus.mem_write;
    end

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          rds;
        int          wrs;
    } exp_t;
    exp_t sb_q[$];

    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int lat, input int rds, input int wrs);
        exp_t e;
        int   n, rd0, wr0;
        logic got, rdy1;
        e.tag = tag; e.rdata = exp_rdata; e.err = exp_err; e.lat = lat; e.rds = rds; e.wrs = wrs;
        sb_q.push_back(e);
        @(negedge clk);
        bus.req_write = wr; bus.req_size = sz; bus.req_unsigned = uns;
        bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        rd0 = rd_pulses; wr0 = wr_pulses;
        #1 bus.req_valid = 1'b0;
        n = 0; got = 1'b0; rdy1 = 1'b1;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            if (n == 1) rdy1 = bus.req_ready;
            if (bus.resp_valid) got = 1'b1;
        end
        e = sb_q.pop_front();
        if (!got) begin
            chk({e.tag, "_resp_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({e.tag, "_lat"},   32'(n), 32'(e.lat));
            chk({e.tag, "_rdata"}, bus.resp_rdata, e.rdata);
            chk({e.tag, "_err"},   32'(bus.resp_error), 32'(e.err));
            chk({e.tag, "_rds"},   32'(rd_pulses - rd0), 32'(e.rds));
            chk({e.tag, "_wrs"},   32'(wr_pulses - wr0), 32'(e.wrs));
            chk({e.tag, "_busy"},  32'(rdy1), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bt [4];
        int n, resp0;
        bt[0] = 8'h88; bt[1] = 8'h99; bt[2] = 8'hAA; bt[3] = 8'hBB;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        for (int i = 0; i < 512; i++) mem[i] = '0;
        mem[9'h040] = 32'h8899AABB;
        mem[9'h042] = 32'h11223344;
        mem[9'h1FF] = 32'hCAFEF00D;

        // Reset state
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp",  32'(bus.resp_valid), 32'd0);
        chk("rst_rd",    32'(bus.mem_read), 32'd0);
        chk("rst_wr",    32'(bus.mem_write), 32'd0);
        chk("rst_addr",  bus.mem_address, 32'h0);
        chk("rst_rdata", bus.resp_rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Byte loads, signed and unsigned
        do_req("lb_101",  1'b0, SIZE_BYTE, 1'b0, 32'h101, 32'h0, 32'hFFFFFF99, 1'b0, 3, 1, 0);
        do_req("lbu_101", 1'b0, SIZE_BYTE, 1'b1, 32'h101, 32'h0, 32'h00000099, 1'b0, 3, 1, 0);
        for (int i = 0; i < 4; i++) begin
            do_req($sformatf("lb_off%0d", i),  1'b0, SIZE_BYTE, 1'b0, 32'h100 + 32'(i), 32'h0,
                   {{24{bt[i][7]}}, bt[i]}, 1'b0, 3, 1, 0);
            do_req($sformatf("lbu_off%0d", i), 1'b0, SIZE_BYTE, 1'b1, 32'h100 + 32'(i), 32'h0,
                   {24'h0, bt[i]}, 1'b0, 3, 1, 0);
        end

        // Sub-word stores (read-modify-write)
        do_req("sb_102", 1'b1, SIZE_BYTE, 1'b0, 32'h102, 32'h12345677, 32'h0, 1'b0, 5, 1, 1);
        chk("sb_102_mem", mem[9'h040], 32'h889977BB);
        do_req("sh_100", 1'b1, SIZE_HALF, 1'b0, 32'h100, 32'hFFFF1234, 32'h0, 1'b0, 5, 1, 1);
        chk("sh_100_mem", mem[9'h040], 32'h123477BB);

        // Word store then load-back
        do_req("sw_104", 1'b1, SIZE_WORD, 1'b0, 32'h104, 32'hDEADBEEF, 32'h0, 1'b0, 3, 0, 1);
        chk("sw_104_mem", mem[9'h041], 32'hDEADBEEF);
        do_req("lw_104", 1'b0, SIZE_WORD, 1'b0, 32'h104, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1, 0);

        // Errors and range boundary
        do_req("lh_103_mis", 1'b0, SIZE_HALF, 1'b0, 32'h103, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        do_req("lw_102_mis", 1'b0, SIZE_WORD, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        do_req("size11",     1'b0, 2'b11,     1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        do_req("lw_7fc",     1'b0, SIZE_WORD, 1'b0, 32'h7FC, 32'h0, 32'hCAFEF00D, 1'b0, 3, 1, 0);
        do_req("lw_800",     1'b0, SIZE_WORD, 1'b0, 32'h800, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        do_req("lb_7ff",     1'b0, SIZE_BYTE, 1'b0, 32'h7FF, 32'h0, 32'h0000000D, 1'b0, 3, 1, 0);
        do_req("sb_900",     1'b1, SIZE_BYTE, 1'b0, 32'h900, 32'h55, 32'h0, 1'b1, 1, 0, 0);

        // Half loads
        mem[9'h040] = 32'h8899AABB;
        do_req("lhu_102", 1'b0, SIZE_HALF, 1'b1, 32'h102, 32'h0, 32'h0000AABB, 1'b0, 3, 1, 0);
        do_req("lh_102",  1'b0, SIZE_HALF, 1'b0, 32'h102, 32'h0, 32'hFFFFAABB, 1'b0, 3, 1, 0);
        do_req("lh_100",  1'b0, SIZE_HALF, 1'b0, 32'h100, 32'h0, 32'hFFFF8899, 1'b0, 3, 1, 0);
        do_req("lhu_100", 1'b0, SIZE_HALF, 1'b1, 32'h100, 32'h0, 32'h00008899, 1'b0, 3, 1, 0);

        // Reset during the write phase of a byte store
        @(negedge clk);
        bus.req_write = 1'b1; bus.req_size = SIZE_BYTE; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h108; bus.req_wdata = 32'h000000AA; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n = 0;
        while (!bus.mem_write && n < 10) begin @(negedge clk); n++; end
        chk("rst_wr_seen", 32'(bus.mem_write), 32'd1);
        resp0 = resp_pulses;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_wr", 32'(bus.mem_write), 32'd0);
        chk("rst_mid_rd", 32'(bus.mem_read), 32'd0);
        chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_no_resp", 32'(resp_pulses - resp0), 32'd0);
        chk("rst_committed", mem[9'h042], 32'hAA223344);
        do_req("lw_108", 1'b0, SIZE_WORD, 1'b0, 32'h108, 32'h0, 32'hAA223344, 1'b0, 3, 1, 0);

        chk("strobe_rules", 32'(strobe_viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
